// File: rtl/digit_step_ctrl_pkg.sv
// Shared types and constants for the minutes/seconds digit step controller.
package digit_step_pkg;

    // Button-handling FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } step_state_e;

    // Largest legal value of each BCD digit (count runs 00..59).
    localparam int unsigned UNITS_MAX = 9;
    localparam int unsigned TENS_MAX  = 5;

    // Larger of two cycle counts; sizes the shared interval counter.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/digit_step_ctrl_if.sv
// Button levels in, step pulses and digit pair out.
// master: the step controller; slave: whoever drives buttons and watches the count.
interface digit_step_ctrl_if;
    logic       btn_up;
    logic       btn_dn;
    logic       add;
    logic       sub;
    logic [3:0] units;
    logic [3:0] tens;
    logic       wrap;

    modport master (
        input  btn_up,
        input  btn_dn,
        output add,
        output sub,
        output units,
        output tens,
        output wrap
    );

    modport slave (
        output btn_up,
        output btn_dn,
        input  add,
        input  sub,
        input  units,
        input  tens,
        input  wrap
    );
endinterface

// File: rtl/digit_step_ctrl_mod_counter.sv
// One BCD digit counting modulo MAX+1. carry/borrow are combinational and
// flag that the current inc/dec request wraps this digit, so the next digit
// can be stepped in the same clock edge.
module digit_mod_counter #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] q,
    output logic       carry,
    output logic       borrow
);

    logic [3:0] q_r;

    assign carry  = inc && (q_r == 4'(MAX));
    assign borrow = dec && (q_r == 4'd0);
    assign q      = q_r;

    // Digit register: wrap at MAX going up and at 0 going down.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= 4'd0;
        end else if (inc && !dec) begin
            q_r <= carry ? 4'd0 : (q_r + 4'd1);
        end else if (dec && !inc) begin
            q_r <= borrow ? 4'(MAX) : (q_r - 4'd1);
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/digit_step_ctrl.sv
// Turns held up/down button levels into single-cycle add/sub steps
// (initial step, hold delay, auto-repeat) and keeps the BCD 00..59 count
// those steps act on. Step pulses, wrap and the new count share one edge.
module digit_step_ctrl
    import digit_step_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 50,
    parameter int unsigned REPEAT_CYCLES = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    digit_step_ctrl_if.master  bus
);

    localparam int unsigned CNT_MAX = max2(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // Counter value at which the pending step fires (counter is cleared on
    // every step, so it never climbs past CNT_MAX-1).
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    step_state_e      state_r;
    step_state_e      state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             dir_up_r;
    logic             dir_up_s;
    logic             step_s;
    logic             step_up_s;
    logic             step_dn_s;
    logic             lat_btn_s;
    logic             oth_btn_s;
    logic [CNT_W-1:0] last_s;

    logic             add_r;
    logic             sub_r;
    logic             wrap_r;

    logic [3:0]       units_q_s;
    logic [3:0]       tens_q_s;
    logic             units_carry_s;
    logic             units_borrow_s;
    logic             tens_carry_s;
    logic             tens_borrow_s;
    logic             wrap_s;

    // Next-state, interval counter and step decision for the button FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        dir_up_s  = dir_up_r;
        step_s    = 1'b0;
        lat_btn_s = dir_up_r ? bus.btn_up : bus.btn_dn;
        oth_btn_s = dir_up_r ? bus.btn_dn : bus.btn_up;
        last_s    = (state_r == HOLD) ? HOLD_LAST : REPEAT_LAST;

        case (state_r)
            IDLE: begin
                if (bus.btn_up && bus.btn_dn) begin
                    state_s = LOCK;
                    cnt_s   = '0;
                end else if (bus.btn_up || bus.btn_dn) begin
                    step_s   = 1'b1;
                    dir_up_s = bus.btn_up;
                    cnt_s    = '0;
                    state_s  = HOLD;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD, REPEAT: begin
                // A conflicting press wins over a release so the opposite
                // direction never steps without both buttons going low first.
                if (oth_btn_s) begin
                    state_s = LOCK;
                    cnt_s   = '0;
                end else if (!lat_btn_s) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == last_s) begin
                    step_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = REPEAT;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            LOCK: begin
                if (!bus.btn_up && !bus.btn_dn) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOCK;
                end
                cnt_s = '0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase

        step_up_s = step_s && dir_up_s;
        step_dn_s = step_s && !dir_up_s;
    end

    // FSM, interval counter and registered step/wrap pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            dir_up_r <= 1'b0;
            add_r    <= 1'b0;
            sub_r    <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            dir_up_r <= dir_up_s;
            add_r    <= step_up_s;
            sub_r    <= step_dn_s;
            wrap_r   <= wrap_s;
        end
    end

    digit_mod_counter #(.MAX(UNITS_MAX)) u_units (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (step_up_s),
        .dec    (step_dn_s),
        .q      (units_q_s),
        .carry  (units_carry_s),
        .borrow (units_borrow_s)
    );

    digit_mod_counter #(.MAX(TENS_MAX)) u_tens (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (units_carry_s),
        .dec    (units_borrow_s),
        .q      (tens_q_s),
        .carry  (tens_carry_s),
        .borrow (tens_borrow_s)
    );

    // The units carry/borrow is only raised while that digit is being
    // stepped, so it already carries the step qualification into tens.
    assign wrap_s = tens_carry_s || tens_borrow_s;

    assign bus.add   = add_r;
    assign bus.sub   = sub_r;
    assign bus.wrap  = wrap_r;
    assign bus.units = units_q_s;
    assign bus.tens  = tens_q_s;

endmodule

// File: tb/tb_digit_step_ctrl.sv
// Directed bench for digit_step_ctrl with HOLD_CYCLES=4, REPEAT_CYCLES=2.
module tb_digit_step_ctrl;
    import digit_step_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   pulses;

    digit_step_ctrl_if bus ();

    digit_step_ctrl #(
        .HOLD_CYCLES   (4),
        .REPEAT_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle press of a single button, followed by one released cycle.
    task automatic tap(input bit up);
        bus.btn_up = up;
        bus.btn_dn = !up;
        tick();
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        tick();
        tick();
        chk("rst_count", {bus.tens, bus.units}, 8'h00);
        chk("rst_pulses", {5'd0, bus.add, bus.sub, bus.wrap}, 8'h00);
        rst_n = 1'b1;

        // Single tap from 00.
        bus.btn_up = 1'b1;
        tick();
        chk("tap_add", bus.add, 8'd1);
        chk("tap_count", {bus.tens, bus.units}, 8'h01);
        bus.btn_up = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(bus.add) + int'(bus.sub);
        end
        chk("tap_no_more", pulses[7:0], 8'd0);
        chk("tap_count_hold", {bus.tens, bus.units}, 8'h01);

        // Auto-repeat: held 12 cycles from 00.
        do_reset();
        bus.btn_up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("rep_add_%0d", i), bus.add,
                {7'd0, (i == 0 || i == 4 || i == 6 || i == 8 || i == 10)});
        end
        bus.btn_up = 1'b0;
        tick();
        chk("rep_release_add", bus.add, 8'd0);
        chk("rep_count", {bus.tens, bus.units}, 8'h05);

        // Preload 59 by taps, then wrap up and back down.
        for (int i = 0; i < 54; i++) tap(1'b1);
        chk("pre59", {bus.tens, bus.units}, 8'h59);
        bus.btn_up = 1'b1;
        tick();
        chk("wrap_up_add_wrap", {6'd0, bus.add, bus.wrap}, 8'h03);
        chk("wrap_up_count", {bus.tens, bus.units}, 8'h00);
        bus.btn_up = 1'b0;
        tick();
        chk("wrap_up_clear", bus.wrap, 8'd0);
        bus.btn_dn = 1'b1;
        tick();
        chk("wrap_dn_sub_wrap", {6'd0, bus.sub, bus.wrap}, 8'h03);
        chk("wrap_dn_count", {bus.tens, bus.units}, 8'h59);
        bus.btn_dn = 1'b0;
        tick();

        // Units/tens boundary 09 <-> 10.
        for (int i = 0; i < 50; i++) tap(1'b0);
        chk("pre09", {bus.tens, bus.units}, 8'h09);
        bus.btn_up = 1'b1;
        tick();
        chk("b_up", {bus.tens, bus.units, 2'b00} >> 2, 8'h10);
        chk("b_up_pulse", {6'd0, bus.add, bus.wrap}, 8'h02);
        bus.btn_up = 1'b0;
        tick();
        bus.btn_dn = 1'b1;
        tick();
        chk("b_dn", {bus.tens, bus.units}, 8'h09);
        chk("b_dn_pulse", {6'd0, bus.sub, bus.wrap}, 8'h02);
        bus.btn_dn = 1'b0;
        tick();

        // Conflict: up held, down joins at cycle 3.
        bus.btn_up = 1'b1;
        tick();
        chk("cf_first", bus.add, 8'd1);
        chk("cf_count", {bus.tens, bus.units}, 8'h10);
        tick();
        tick();
        bus.btn_dn = 1'b1;
        tick();
        chk("cf_lock", {6'd0, dut.state_r}, {6'd0, LOCK});
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(bus.add) + int'(bus.sub);
        end
        bus.btn_dn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(bus.add) + int'(bus.sub);
        end
        chk("cf_no_steps", pulses[7:0], 8'd0);
        chk("cf_still_lock", {6'd0, dut.state_r}, {6'd0, LOCK});
        bus.btn_up = 1'b0;
        tick();
        bus.btn_dn = 1'b1;
        tick();
        chk("cf_dn_sub", {6'd0, bus.add, bus.sub}, 8'h01);
        chk("cf_dn_count", {bus.tens, bus.units}, 8'h09);
        bus.btn_dn = 1'b0;
        tick();

        // Reset in REPEAT at 03 on the edge where a step is due.
        do_reset();
        bus.btn_up = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("mr_count", {bus.tens, bus.units}, 8'h03);
        chk("mr_state", {6'd0, dut.state_r}, {6'd0, REPEAT});
        rst_n = 1'b0;
        tick();
        chk("mr_rst_count", {bus.tens, bus.units}, 8'h00);
        chk("mr_rst_add", bus.add, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("mr_restart_add", bus.add, 8'd1);
        chk("mr_restart_count", {bus.tens, bus.units}, 8'h01);
        bus.btn_up = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_step_ctrl.md
# digit_step_ctrl

Front-end controller that drives the minutes/seconds digit pair of the clock datapath. Converts held up/down button levels into single-cycle add/sub step pulses, with an initial step, a hold delay, and auto-repeat. Maintains the registered two-digit BCD value 00–59 that the step pulses act on. It is the initiator side of the add/sub step interface: it produces the steps and consumes the per-digit wrap/reset condition.

## Interface
- HOLD_CYCLES, 50: cycles a button must stay held after the first step before auto-repeat starts (≥1)
- REPEAT_CYCLES, 10: cycles between auto-repeat steps (≥1)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- btn_up  in  1  up request level, already synchronized/debounced to clk
- btn_dn  in  1  down request level, already synchronized/debounced to clk
- add  out  1  one-cycle increment step pulse
- sub  out  1  one-cycle decrement step pulse
- units  out  4  BCD units digit, 0–9
- tens  out  4  BCD tens digit, 0–5
- wrap  out  1  one-cycle pulse when the count wraps 59→00 or 00→59

## Operation
- Reset (rst_n low at a rising edge) has these effects:
  - All outputs become 0: units=0, tens=0, add=sub=wrap=0.
  - The FSM enters IDLE and the interval counter clears.
  - Reset overrides every other input, including mid-HOLD and mid-REPEAT.
- The FSM has four states:
  - IDLE:
    - Exactly one button high → issue one step, clear interval counter, go to HOLD with direction latched.
    - Both high → LOCK, no step.
    - Neither high → stay.
  - HOLD:
    - Latched button still high and other low → count cycles. When the counter reaches HOLD_CYCLES, issue a step, clear the counter, and go to REPEAT.
    - Latched button low → IDLE, no step.
    - Other button high → LOCK, no step.
  - REPEAT:
    - Same as HOLD, but uses REPEAT_CYCLES and stays in REPEAT after each step.
  - LOCK:
    - No steps.
    - Go to IDLE only when both buttons are low.
    - A direction change always passes through LOCK or IDLE, so it never produces a step directly.
- A step is add=1 (up) or sub=1 (down) for exactly one cycle. add and sub are never high together.
- Counting is mod 60, held as units (mod 10) and tens (mod 6).
  - Up: units 9→0 carries into tens; tens 5 with carry → 0 and wrap=1.
  - Down: units 0→9 borrows from tens; tens 0 with borrow → 5 and wrap=1.
  - units never exceeds 9 and tens never exceeds 5; out-of-range values are unreachable from reset.

## Timing
- Registered outputs: add/sub/wrap and the updated units/tens all change at the same rising edge. The step pulse and the new count are visible together.
- First step: if btn_up is first sampled high at edge N, then add=1 and the count is updated during cycle N..N+1.
- Hold: with the button held continuously, the second step occurs HOLD_CYCLES edges after the first. Each subsequent step occurs REPEAT_CYCLES edges after the previous one.
- Release: if the button is sampled low at edge M, no step occurs at M or later.
- A step due at the same edge as a release or a both-pressed condition is suppressed.
- wrap is high in exactly the same cycle as the step that caused it.
- Interval counter width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1) bits; it must not overflow.

## Structure
- Package digit_step_pkg contains:
  - State enum {IDLE, HOLD, REPEAT, LOCK}.
  - Constants UNITS_MAX=9 and TENS_MAX=5.
- Sub-module digit_mod_counter is instantiated twice (units, tens):
  - Parameter MAX.
  - Inputs clk, rst_n, inc, dec.
  - Outputs q[3:0], carry (inc at MAX), borrow (dec at 0).
  - The tens instance is driven by the units carry/borrow gated with the step; tens carry/borrow forms wrap.

## Test plan
Run with HOLD_CYCLES=4, REPEAT_CYCLES=2.
- Reset, then single tap: btn_up high for 1 cycle from 00 → add pulses once, count 01, no further steps.
- Auto-repeat: btn_up held 12 cycles from 00 → add at cycles 0, 4, 6, 8, 10; final count 05.
- Wrap up/down:
  - Preload to 59 by taps, then tap up → 00 with wrap=1 coincident with add.
  - Tap down → 59 with wrap=1 coincident with sub.
- Units/tens boundary: from 09 tap up → 10; from 10 tap down → 09; wrap stays 0.
- Conflict: btn_up held, btn_dn raised at cycle 3 → no step after the first, FSM in LOCK. Drop btn_dn only → still no steps. Drop both, then tap btn_dn → single sub.
- Reset mid-REPEAT: rst_n low while btn_up held at count 03 → count 00, add=0 next cycle. After rst_n high with btn_up still high → first step issued immediately (IDLE entry), count 01.
